counter_game_arbiter: RTL and testbench

Turn-based controller that shares the single counter-game datapath between two players (A, B). It arbitrates round-robin between their requests and loads the granted player's initial value. While the player holds the turn, it drives that player's 2-bit control code and gates counting. It ends each turn on a WINNER/LOSER event, on timeout or on request drop, keeps per-player scores, and reports match end when the datapath raises GAMEOVER.

---
 rtl/counter_game_arbiter.sv | 152 +++++++++++++++
 tb/tb_counter_game_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_game_arbiter.sv
// counter_game_arbiter
//   Turn-based controller sharing one counter-game datapath between players
//   A and B. Round-robin arbitration grants a turn, loads that player's start
//   value, gates counting for at most TURN_CYCLES cycles, keeps saturating
//   per-player scores and reports the end of a match on GAMEOVER.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   req[1:0]                turn requests (bit0 = A, bit1 = B), level
//   ctrl_a, ctrl_b          per-player 2-bit control codes
//   init_val_a, init_val_b  per-player counter start values
//   winner, loser           datapath WINNER / LOSER pulses
//   gameover, who           datapath GAMEOVER pulse and WHO code
//   grant[1:0]              one-hot turn owner, 00 when nobody plays
//   control                 owner's control code (combinational from grant)
//   initial_value, INIT     registered load value and one-cycle load strobe
//   count_en                datapath count enable
//   score_a, score_b        saturating player scores
//   match_done, match_who   one-cycle match-end pulse and captured WHO
module counter_game_arbiter #(
   parameter int COUNTER_SIZE = 4,
   parameter int TURN_CYCLES  = 8,
   parameter int SCORE_W      = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [1:0]              req,
   input  logic [1:0]              ctrl_a,
   input  logic [1:0]              ctrl_b,
   input  logic [COUNTER_SIZE-1:0] init_val_a,
   input  logic [COUNTER_SIZE-1:0] init_val_b,
   input  logic                    winner,
   input  logic                    loser,
   input  logic                    gameover,
   input  logic [1:0]              who,
   output logic [1:0]              grant,
   output logic [1:0]              control,
   output logic [COUNTER_SIZE-1:0] initial_value,
   output logic                    INIT,
   output logic                    count_en,
   output logic [SCORE_W-1:0]      score_a,
   output logic [SCORE_W-1:0]      score_b,
   output logic                    match_done,
   output logic [1:0]              match_who
);

   localparam int CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TURN_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, PLAY, SWITCH} state_t;

   state_t           state;
   logic             owner;       // 0 = A, 1 = B
   logic             last_owner;  // owner of the most recently completed turn
   logic [CNT_W-1:0] turn_cnt;
   logic             owner_req;
   logic             pick_b;
   logic             turn_over;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (&v) ? v : v + SCORE_W'(1);
   endfunction

   assign owner_req = owner ? req[1] : req[0];
   // On a tie the player who did not play last goes next.
   assign pick_b    = (&req) ? ~last_owner : req[1];
   assign turn_over = winner | loser | (turn_cnt == LAST_CNT) | ~owner_req;

   always_comb begin
      control = 2'b00;
      case (grant)
         2'b01:   control = ctrl_a;
         2'b10:   control = ctrl_b;
         default: control = 2'b00;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         owner         <= 1'b0;
         last_owner    <= 1'b1;
         turn_cnt      <= '0;
         grant         <= 2'b00;
         initial_value <= '0;
         INIT          <= 1'b0;
         count_en      <= 1'b0;
         score_a       <= '0;
         score_b       <= '0;
         match_done    <= 1'b0;
         match_who     <= 2'b00;
      end else begin
         match_done <= 1'b0;
         if (gameover) begin
            // Match end overrides everything; a turn in flight is abandoned
            // without updating last_owner or scoring a coincident winner.
            match_done <= 1'b1;
            match_who  <= who;
            score_a    <= '0;
            score_b    <= '0;
            state      <= IDLE;
            grant      <= 2'b00;
            INIT       <= 1'b0;
            count_en   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  grant    <= 2'b00;
                  count_en <= 1'b0;
                  if (|req) begin
                     owner         <= pick_b;
                     grant         <= pick_b ? 2'b10 : 2'b01;
                     initial_value <= pick_b ? init_val_b : init_val_a;
                     INIT          <= 1'b1;
                     state         <= LOAD;
                  end
               end
               LOAD: begin
                  INIT     <= 1'b0;
                  count_en <= 1'b1;
                  turn_cnt <= '0;
                  state    <= PLAY;
               end
               PLAY: begin
                  turn_cnt <= turn_cnt + CNT_W'(1);
                  // Loser beats winner: only the opponent scores.
                  if (loser) begin
                     if (owner) score_a <= sat_inc(score_a);
                     else       score_b <= sat_inc(score_b);
                  end else if (winner) begin
                     if (owner) score_b <= sat_inc(score_b);
                     else       score_a <= sat_inc(score_a);
                  end
                  if (turn_over) begin
                     state      <= SWITCH;
                     count_en   <= 1'b0;
                     grant      <= 2'b00;
                     last_owner <= owner;
                  end
               end
               SWITCH: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_counter_game_arbiter.sv
// Directed bench for counter_game_arbiter. Per-cycle expected output vectors
// are queued as stimulus is applied and compared after each rising edge.
module tb_counter_game_arbiter;

   logic       clock;
   logic       reset_n;
   logic [1:0] req;
   logic [1:0] ctrl_a;
   logic [1:0] ctrl_b;
   logic [3:0] init_val_a;
   logic [3:0] init_val_b;
   logic       winner;
   logic       loser;
   logic       gameover;
   logic [1:0] who;
   logic [1:0] grant;
   logic [1:0] control;
   logic [3:0] initial_value;
   logic       INIT;
   logic       count_en;
   logic [3:0] score_a;
   logic [3:0] score_b;
   logic       match_done;
   logic [1:0] match_who;

   counter_game_arbiter #(
      .COUNTER_SIZE (4),
      .TURN_CYCLES  (8),
      .SCORE_W      (4)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req           (req),
      .ctrl_a        (ctrl_a),
      .ctrl_b        (ctrl_b),
      .init_val_a    (init_val_a),
      .init_val_b    (init_val_b),
      .winner        (winner),
      .loser         (loser),
      .gameover      (gameover),
      .who           (who),
      .grant         (grant),
      .control       (control),
      .initial_value (initial_value),
      .INIT          (INIT),
      .count_en      (count_en),
      .score_a       (score_a),
      .score_b       (score_b),
      .match_done    (match_done),
      .match_who     (match_who)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Vector layout: grant, INIT, count_en, control, initial_value,
   // score_a, score_b, match_done, match_who (21 bits).
   typedef struct {
      string       tag;
      logic [20:0] val;
   } exp_t;

   exp_t       sb_q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   logic [3:0] e_iv;
   logic [3:0] e_sa;
   logic [3:0] e_sb;
   logic [1:0] e_mw;

   task automatic push(input string tag, input logic [1:0] g, input logic ini,
                       input logic en, input logic [1:0] ctl, input logic md);
      exp_t e;
      e.tag = tag;
      e.val = {g, ini, en, ctl, e_iv, e_sa, e_sb, md, e_mw};
      sb_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t        e;
      logic [20:0] o;
      o = {grant, INIT, count_en, control, initial_value,
           score_a, score_b, match_done, match_who};
      n_vec++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_underflow: observed %h required an expectation", o);
      end else begin
         e = sb_q.pop_front();
         assert (o === e.val) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic cyc(input string tag, input logic [1:0] g, input logic ini,
                      input logic en, input logic [1:0] ctl, input logic md);
      push(tag, g, ini, en, ctl, md);
      tick();
      check_out();
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         tick();
         check_out();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b1; req = 2'b00; ctrl_a = 2'b00; ctrl_b = 2'b00;
      init_val_a = 4'd0; init_val_b = 4'd0;
      winner = 1'b0; loser = 1'b0; gameover = 1'b0; who = 2'b00;
      e_iv = 4'd0; e_sa = 4'd0; e_sb = 4'd0; e_mw = 2'b00;

      // Reset state
      #3 reset_n = 1'b0;
      #1;
      push("reset", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      check_out();
      tick();
      tick();
      push("reset_hold", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      check_out();

      // Test 1: single requester A, full 8-cycle turn
      req = 2'b01; init_val_a = 4'd5; ctrl_a = 2'b00;
      reset_n = 1'b1;
      e_iv = 4'd5;
      push("t1_load", 2'b01, 1'b1, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 8; i++)
         push($sformatf("t1_play%0d", i), 2'b01, 1'b0, 1'b1, 2'b00, 1'b0);
      push("t1_switch", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      drain(10);
      req = 2'b00;
      cyc("t1_idle0", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      cyc("t1_idle1", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

      // Test 2: both request from reset, alternation A, B, A, B
      #2 reset_n = 1'b0;
      req = 2'b11; ctrl_a = 2'b01; ctrl_b = 2'b10;
      init_val_a = 4'd3; init_val_b = 4'd9;
      e_iv = 4'd0;
      #1;
      push("t2_reset", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      check_out();
      #2 reset_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         logic       own_a;
         logic [1:0] g;
         own_a = (t % 2 == 0);
         g     = own_a ? 2'b01 : 2'b10;
         e_iv  = own_a ? 4'd3 : 4'd9;
         push($sformatf("t2_load%0d", t), g, 1'b1, 1'b0, g, 1'b0);
         for (int i = 0; i < 8; i++)
            push($sformatf("t2_turn%0d_play%0d", t, i), g, 1'b0, 1'b1, g, 1'b0);
         push($sformatf("t2_switch%0d", t), 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
         push($sformatf("t2_idle%0d", t), 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      end
      drain(44);

      // Test 3: winner ends A's turn, loser during B's turn scores A
      e_iv = 4'd3;
      cyc("t3_load_a", 2'b01, 1'b1, 1'b0, 2'b01, 1'b0);
      cyc("t3_play0", 2'b01, 1'b0, 1'b1, 2'b01, 1'b0);
      cyc("t3_play1", 2'b01, 1'b0, 1'b1, 2'b01, 1'b0);
      cyc("t3_play2", 2'b01, 1'b0, 1'b1, 2'b01, 1'b0);
      winner = 1'b1;
      e_sa = 4'd1;
      cyc("t3_win_switch", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      winner = 1'b0;
      cyc("t3_idle", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      e_iv = 4'd9;
      cyc("t3_load_b", 2'b10, 1'b1, 1'b0, 2'b10, 1'b0);
      cyc("t3_play_b", 2'b10, 1'b0, 1'b1, 2'b10, 1'b0);
      loser = 1'b1;
      e_sa = 4'd2;
      cyc("t3_lose_switch", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      loser = 1'b0;
      req = 2'b01;

      // Test 4: winner outside PLAY ignored; winner+loser together saturates B
      winner = 1'b1;
      cyc("t4_idle_win", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      for (int r = 0; r < 16; r++) begin
         e_iv = 4'd3;
         cyc($sformatf("t4_load%0d", r), 2'b01, 1'b1, 1'b0, 2'b01, 1'b0);
         winner = 1'b0;
         cyc($sformatf("t4_play%0d", r), 2'b01, 1'b0, 1'b1, 2'b01, 1'b0);
         winner = 1'b1; loser = 1'b1;
         if (e_sb != 4'd15) e_sb = e_sb + 4'd1;
         cyc($sformatf("t4_both%0d", r), 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
         winner = 1'b0; loser = 1'b0;
         cyc($sformatf("t4_idle%0d", r), 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      end

      // Test 5: gameover during PLAY with a coincident winner
      cyc("t5_load", 2'b01, 1'b1, 1'b0, 2'b01, 1'b0);
      cyc("t5_play", 2'b01, 1'b0, 1'b1, 2'b01, 1'b0);
      gameover = 1'b1; who = 2'b10; winner = 1'b1;
      e_sa = 4'd0; e_sb = 4'd0; e_mw = 2'b10;
      cyc("t5_gameover", 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
      gameover = 1'b0; winner = 1'b0; who = 2'b01;
      cyc("t5_reload", 2'b01, 1'b1, 1'b0, 2'b01, 1'b0);

      // Test 6: asynchronous reset mid-PLAY, then B alone, then request drop
      cyc("t6_play", 2'b01, 1'b0, 1'b1, 2'b01, 1'b0);
      #2 reset_n = 1'b0;
      e_iv = 4'd0; e_mw = 2'b00;
      #1;
      push("t6_async_reset", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      check_out();
      req = 2'b10; ctrl_b = 2'b11;
      #2 reset_n = 1'b1;
      e_iv = 4'd9;
      cyc("t6_load_b", 2'b10, 1'b1, 1'b0, 2'b11, 1'b0);
      cyc("t6_play_b", 2'b10, 1'b0, 1'b1, 2'b11, 1'b0);
      req = 2'b00;
      cyc("t6_req_drop", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      cyc("t6_idle", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

      if (sb_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
